// File: rtl/arm_dp_issue.sv
// arm_dp_issue: issue/retire controller for ARM data-processing instructions.
// Accepts one instruction at a time and evaluates its condition against the
// held NZCV flags. A passing instruction drives the ALU for one cycle, then
// retires with a writeback strobe. A failing instruction retires as a no-op
// and bumps the skip counter.
module arm_dp_issue #(
    parameter int         CNT_W      = 16,
    parameter logic [3:0] INIT_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       alu_sel,
    output logic             alu_cin,
    output logic [3:0]       rn_idx,
    output logic [3:0]       rm_idx,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             wb_en,
    output logic [3:0]       wb_idx,
    output logic             done,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] skip_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RETIRE, SKIP} state_t;

    state_t      state;
    logic [31:0] ir;          // latched instruction
    logic        cond_pass;
    logic        fn, fz, fc, fv;
    logic [3:0]  op;
    logic        is_cmp;      // TST/TEQ/CMP/CMN: flag-setting, no writeback
    logic        is_arith;    // arithmetic ops update C and V from the ALU
    logic        upd_flags;

    assign {fn, fz, fc, fv} = flags;
    assign op        = ir[24:21];
    assign is_cmp    = (op[3:2] == 2'b10);
    assign is_arith  = (op inside {[4'd2:4'd7], 4'ha, 4'hb});
    assign upd_flags = ir[20] | is_cmp;

    // Condition-field evaluation against the currently held flags
    always_comb begin
        cond_pass = 1'b0;
        case (instr[31:28])
            4'h0: cond_pass = fz;
            4'h1: cond_pass = !fz;
            4'h2: cond_pass = fc;
            4'h3: cond_pass = !fc;
            4'h4: cond_pass = fn;
            4'h5: cond_pass = !fn;
            4'h6: cond_pass = fv;
            4'h7: cond_pass = !fv;
            4'h8: cond_pass = fc & !fz;
            4'h9: cond_pass = !fc | fz;
            4'ha: cond_pass = (fn == fv);
            4'hb: cond_pass = (fn != fv);
            4'hc: cond_pass = !fz & (fn == fv);
            4'hd: cond_pass = fz | (fn != fv);
            4'he: cond_pass = 1'b1;
            default: cond_pass = 1'b0;   // 0xF never executes
        endcase
    end

    // Control FSM with registered outputs; flags commit at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ir         <= '0;
            in_ready   <= 1'b1;
            alu_sel    <= '0;
            alu_cin    <= 1'b0;
            rn_idx     <= '0;
            rm_idx     <= '0;
            wb_en      <= 1'b0;
            wb_idx     <= '0;
            done       <= 1'b0;
            flags      <= INIT_FLAGS;
            skip_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ir       <= instr;
                        in_ready <= 1'b0;
                        if (cond_pass) begin
                            state   <= EXEC;
                            alu_sel <= {1'b0, instr[24:21]};
                            alu_cin <= fc;
                            rn_idx  <= instr[19:16];
                            rm_idx  <= instr[3:0];
                        end else begin
                            state      <= SKIP;
                            done       <= 1'b1;
                            skip_count <= skip_count + CNT_W'(1);
                        end
                    end
                end
                EXEC: begin
                    state  <= RETIRE;
                    done   <= 1'b1;
                    wb_en  <= !is_cmp;
                    wb_idx <= ir[15:12];
                    if (upd_flags) begin
                        if (is_arith) flags <= {alu_n, alu_z, alu_c, alu_v};
                        else          flags <= {alu_n, alu_z, fc, fv};
                    end
                end
                RETIRE, SKIP: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    wb_en    <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
